uart_rx_depacketizer: RTL and testbench

Serial receive stage directly downstream of uart_packetizer_top. It consumes the 8N1 stream that block drives on serial_out and deserialises each frame. Valid bytes go into a show-ahead output FIFO with a valid/ready read port. Framing errors and FIFO overruns are flagged; the transmit side is shared-clock, but the receiver makes no phase assumption.

---
 rtl/uart_rx_depacketizer.sv | 197 +++++++++++++++++++
 tb/tb_uart_rx_depacketizer.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_depacketizer.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_depacketizer
// Brief    : 8N1 serial receiver feeding a show-ahead valid/ready output FIFO,
//            with framing-error and overrun pulses.
// Revision : 1.0  initial release
// ============================================================================
module uart_rx_depacketizer #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  serial_in,
    input  logic                  rx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  fifo_full,
    output logic                  rx_busy,
    output logic                  frame_err,
    output logic                  overrun
);

    localparam int C_BAUD_DIV = CLK_FREQ / BAUD_RATE;
    localparam int C_HALF_BIT = C_BAUD_DIV / 2;
    localparam int C_TMR_W    = $clog2(C_BAUD_DIV);
    localparam int C_BIT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int C_PTR_W    = $clog2(FIFO_DEPTH);
    localparam int C_CNT_W    = C_PTR_W + 1;

    localparam logic [C_TMR_W-1:0] C_HALF_LAST = C_TMR_W'(C_HALF_BIT - 1);
    localparam logic [C_TMR_W-1:0] C_BIT_LAST  = C_TMR_W'(C_BAUD_DIV - 1);
    localparam logic [C_TMR_W-1:0] C_TMR_ONE   = C_TMR_W'(1);
    localparam logic [C_BIT_W-1:0] C_DATA_LAST = C_BIT_W'(DATA_WIDTH - 1);
    localparam logic [C_BIT_W-1:0] C_BIT_ONE   = C_BIT_W'(1);
    localparam logic [C_PTR_W-1:0] C_PTR_ONE   = C_PTR_W'(1);
    localparam logic [C_CNT_W-1:0] C_CNT_ONE   = C_CNT_W'(1);
    localparam logic [C_CNT_W-1:0] C_FULL_CNT  = C_CNT_W'(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE      = 3'b000;
    localparam logic [2:0] S_START     = 3'b001;
    localparam logic [2:0] S_DATA      = 3'b010;
    localparam logic [2:0] S_STOP      = 3'b011;
    localparam logic [2:0] S_WAIT_IDLE = 3'b100;

    logic                  r_sync_0;
    logic                  r_sync_1;
    logic [2:0]            r_state;
    logic [C_TMR_W-1:0]    r_timer;
    logic [C_BIT_W-1:0]    r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_frame_err;
    logic                  r_overrun;

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [C_PTR_W-1:0]    r_wr_ptr;
    logic [C_PTR_W-1:0]    r_rd_ptr;
    logic [C_CNT_W-1:0]    r_count;

    logic w_line;
    logic w_timer_half;
    logic w_timer_full;
    logic w_stop_sample;
    logic w_push_req;
    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push;

    // The line is asynchronous to clk; idle-high reset value avoids a false start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync_0 <= 1'b1;
            r_sync_1 <= 1'b1;
        end else begin
            r_sync_0 <= serial_in;
            r_sync_1 <= r_sync_0;
        end
    end

    assign w_line        = r_sync_1;
    assign w_timer_half  = (r_timer == C_HALF_LAST);
    assign w_timer_full  = (r_timer == C_BIT_LAST);
    assign w_stop_sample = (r_state == S_STOP) && w_timer_full;
    assign w_push_req    = w_stop_sample && w_line;

    assign w_full  = (r_count == C_FULL_CNT);
    assign w_empty = (r_count == '0);
    assign w_pop   = !w_empty && rx_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign w_push  = w_push_req && (!w_full || w_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_timer   <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_timer <= '0;
                    if (!w_line) begin
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_timer_half) begin
                        r_timer   <= '0;
                        r_bit_cnt <= '0;
                        r_state   <= w_line ? S_IDLE : S_DATA;
                    end else begin
                        r_timer <= r_timer + C_TMR_ONE;
                    end
                end
                S_DATA: begin
                    if (w_timer_full) begin
                        r_timer <= '0;
                        r_shift <= {w_line, r_shift[DATA_WIDTH-1:1]};
                        if (r_bit_cnt == C_DATA_LAST) begin
                            r_state <= S_STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + C_BIT_ONE;
                        end
                    end else begin
                        r_timer <= r_timer + C_TMR_ONE;
                    end
                end
                S_STOP: begin
                    if (w_timer_full) begin
                        r_timer <= '0;
                        r_state <= w_line ? S_IDLE : S_WAIT_IDLE;
                    end else begin
                        r_timer <= r_timer + C_TMR_ONE;
                    end
                end
                S_WAIT_IDLE: begin
                    // Hold off until the break ends so it yields a single error.
                    if (w_line) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_timer <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_stop_sample && !w_line;
            r_overrun   <= w_push_req && w_full && !w_pop;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_shift;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + C_CNT_ONE;
                2'b01:   r_count <= r_count - C_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    assign rx_valid  = !w_empty;
    assign rx_data   = w_empty ? '0 : r_mem[r_rd_ptr];
    assign fifo_full = w_full;
    assign rx_busy   = (r_state != S_IDLE);
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_depacketizer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_uart_rx_depacketizer
// Brief    : Directed self-checking bench; 64 clocks per bit (6.4 MHz / 100 kBd).
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx_depacketizer;

    localparam int CLK_FREQ   = 6_400_000;
    localparam int BAUD_RATE  = 100_000;
    localparam int DATA_WIDTH = 8;
    localparam int FIFO_DEPTH = 16;
    localparam int DIV        = 64;
    localparam int HALF       = 32;
    // Pin falling edge to stop-sample edge: 2 sync flops + idle decision + half + 9 bits.
    localparam int STOP_EDGE  = 3 + HALF + 9 * DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       serial_in = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       fifo_full;
    logic       rx_busy;
    logic       frame_err;
    logic       overrun;

    int n_checks = 0;
    int n_fail   = 0;
    int fe_cnt   = 0;
    int ov_cnt   = 0;
    logic [7:0] rxq [$];
    logic watch_full   = 1'b0;
    logic full_dropped = 1'b0;

    uart_rx_depacketizer #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD_RATE  (BAUD_RATE),
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .serial_in (serial_in),
        .rx_ready  (rx_ready),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .fifo_full (fifo_full),
        .rx_busy   (rx_busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err === 1'b1) fe_cnt++;
        if (overrun === 1'b1) ov_cnt++;
        if (rx_valid === 1'b1 && rx_ready === 1'b1) rxq.push_back(rx_data);
        if (watch_full && fifo_full !== 1'b1) full_dropped = 1'b1;
    end

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_val, input int stop_bits);
        serial_in = 1'b0;
        wait_cycles(DIV);
        for (int i = 0; i < 8; i++) begin
            serial_in = d[i];
            wait_cycles(DIV);
        end
        serial_in = stop_val;
        wait_cycles(DIV * stop_bits);
    endtask

    task automatic test_reset();
        wait_cycles(3);
        n_checks++;
        if ({rx_data, rx_valid, fifo_full, rx_busy, frame_err, overrun} !== 13'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0000",
                     {rx_data, rx_valid, fifo_full, rx_busy, frame_err, overrun});
        end
        rst = 1'b1;
        wait_cycles(4);
    endtask

    task automatic test_single_frame();
        int q0, fe0, ov0;
        q0 = rxq.size(); fe0 = fe_cnt; ov0 = ov_cnt;
        rx_ready = 1'b1;
        fork
            send_frame(8'hA5, 1'b1, 1);
            begin
                wait_cycles(STOP_EDGE - 1);
                n_checks++;
                if (rx_valid !== 1'b0) begin
                    n_fail++; $display("FAIL a5_before_stop: rx_valid=%b expected 0", rx_valid);
                end
                wait_cycles(1);
                n_checks++;
                if (rx_valid !== 1'b1 || rx_data !== 8'hA5) begin
                    n_fail++;
                    $display("FAIL a5_after_stop: valid=%b data=%h expected 1/a5", rx_valid, rx_data);
                end
                wait_cycles(1);
                n_checks++;
                if (rx_valid !== 1'b0) begin
                    n_fail++; $display("FAIL a5_popped: rx_valid=%b expected 0", rx_valid);
                end
            end
        join
        wait_cycles(4);
        n_checks++;
        if (rxq.size() != q0 + 1 || rxq[q0] !== 8'hA5) begin
            n_fail++; $display("FAIL a5_received: count=%0d expected 1", rxq.size() - q0);
        end
        n_checks++;
        if (fe_cnt != fe0 || ov_cnt != ov0) begin
            n_fail++;
            $display("FAIL a5_flags: fe=%0d ov=%0d expected 0/0", fe_cnt - fe0, ov_cnt - ov0);
        end
    endtask

    task automatic test_overrun();
        int q0, ov0;
        logic [7:0] b;
        q0 = rxq.size();
        rx_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            b = 8'h30 + 8'(i);
            send_frame(b, 1'b1, 1);
            if (i == 14) begin
                n_checks++;
                if (fifo_full !== 1'b0) begin
                    n_fail++; $display("FAIL full_at_15: fifo_full=%b expected 0", fifo_full);
                end
            end
        end
        wait_cycles(5);
        n_checks++;
        if (fifo_full !== 1'b1 || rx_valid !== 1'b1 || rx_data !== 8'h30) begin
            n_fail++;
            $display("FAIL full_at_16: full=%b valid=%b data=%h expected 1/1/30",
                     fifo_full, rx_valid, rx_data);
        end
        ov0 = ov_cnt;
        send_frame(8'h40, 1'b1, 1);
        wait_cycles(5);
        n_checks++;
        if (ov_cnt - ov0 != 1 || fifo_full !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_pulse: pulses=%0d full=%b expected 1/1", ov_cnt - ov0, fifo_full);
        end
        rx_ready = 1'b1;
        wait_cycles(24);
        rx_ready = 1'b0;
        n_checks++;
        if (rxq.size() - q0 != 16) begin
            n_fail++; $display("FAIL drain_count: got %0d expected 16", rxq.size() - q0);
        end else begin
            for (int i = 0; i < 16; i++) begin
                b = 8'h30 + 8'(i);
                n_checks++;
                if (rxq[q0 + i] !== b) begin
                    n_fail++; $display("FAIL drain_order[%0d]: got %h expected %h", i, rxq[q0 + i], b);
                end
            end
        end
        n_checks++;
        if (rx_valid !== 1'b0 || rx_data !== 8'h00) begin
            n_fail++; $display("FAIL drain_empty: valid=%b data=%h expected 0/00", rx_valid, rx_data);
        end
    endtask

    task automatic test_frame_error();
        int q0, fe0;
        q0 = rxq.size(); fe0 = fe_cnt;
        rx_ready = 1'b1;
        send_frame(8'h5A, 1'b0, 2);
        n_checks++;
        if (fe_cnt - fe0 != 1) begin
            n_fail++; $display("FAIL frame_err_pulse: cycles=%0d expected 1", fe_cnt - fe0);
        end
        n_checks++;
        if (rx_busy !== 1'b1) begin
            n_fail++; $display("FAIL break_busy: rx_busy=%b expected 1", rx_busy);
        end
        serial_in = 1'b1;
        wait_cycles(6);
        n_checks++;
        if (rx_busy !== 1'b0 || rxq.size() != q0 || rx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL break_recover: busy=%b pushed=%0d expected 0/0", rx_busy, rxq.size() - q0);
        end
        send_frame(8'h3C, 1'b1, 1);
        wait_cycles(4);
        n_checks++;
        if (rxq.size() != q0 + 1 || rxq[q0] !== 8'h3C || fe_cnt - fe0 != 1) begin
            n_fail++;
            $display("FAIL after_break: count=%0d fe=%0d expected 1 byte 3c, fe 1",
                     rxq.size() - q0, fe_cnt - fe0);
        end
    endtask

    task automatic test_glitch();
        int q0, fe0, ov0;
        q0 = rxq.size(); fe0 = fe_cnt; ov0 = ov_cnt;
        serial_in = 1'b0;
        wait_cycles(15);
        serial_in = 1'b1;
        n_checks++;
        if (rx_busy !== 1'b1) begin
            n_fail++; $display("FAIL glitch_start: rx_busy=%b expected 1", rx_busy);
        end
        wait_cycles(HALF);
        n_checks++;
        if (rx_busy !== 1'b0 || rx_valid !== 1'b0 || rxq.size() != q0
            || fe_cnt != fe0 || ov_cnt != ov0) begin
            n_fail++;
            $display("FAIL glitch_reject: busy=%b valid=%b fe=%0d ov=%0d expected all 0",
                     rx_busy, rx_valid, fe_cnt - fe0, ov_cnt - ov0);
        end
    endtask

    task automatic test_reset_mid_frame();
        int q0;
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b1, 1);
        wait_cycles(4);
        n_checks++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin
            n_fail++; $display("FAIL pre_reset_byte: valid=%b data=%h expected 1/11", rx_valid, rx_data);
        end
        serial_in = 1'b0;
        wait_cycles(DIV);
        for (int i = 0; i < 4; i++) wait_cycles(DIV);
        serial_in = 1'b1;
        wait_cycles(DIV / 2);
        n_checks++;
        if (rx_busy !== 1'b1) begin
            n_fail++; $display("FAIL mid_frame_busy: rx_busy=%b expected 1", rx_busy);
        end
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if ({rx_data, rx_valid, fifo_full, rx_busy, frame_err, overrun} !== 13'h0) begin
            n_fail++;
            $display("FAIL async_reset: got %h expected 0000",
                     {rx_data, rx_valid, fifo_full, rx_busy, frame_err, overrun});
        end
        @(posedge clk);
        #1;
        wait_cycles(3);
        rst = 1'b1;
        wait_cycles(2 * DIV);
        n_checks++;
        if ({rx_data, rx_valid, rx_busy} !== 10'h0) begin
            n_fail++; $display("FAIL post_reset_idle: got %h expected 000", {rx_data, rx_valid, rx_busy});
        end
        rx_ready = 1'b1;
        q0 = rxq.size();
        send_frame(8'h0F, 1'b1, 1);
        wait_cycles(4);
        n_checks++;
        if (rxq.size() != q0 + 1 || rxq[q0] !== 8'h0F) begin
            n_fail++; $display("FAIL post_reset_frame: count=%0d expected one 0f", rxq.size() - q0);
        end
    endtask

    task automatic test_full_pop_push();
        int q0, ov0;
        logic [7:0] b;
        q0 = rxq.size();
        rx_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            b = 8'h60 + 8'(i);
            send_frame(b, 1'b1, 1);
        end
        wait_cycles(4);
        n_checks++;
        if (fifo_full !== 1'b1) begin
            n_fail++; $display("FAIL refill_full: fifo_full=%b expected 1", fifo_full);
        end
        ov0 = ov_cnt;
        full_dropped = 1'b0;
        watch_full = 1'b1;
        fork
            send_frame(8'h77, 1'b1, 1);
            begin
                wait_cycles(STOP_EDGE - 1);
                rx_ready = 1'b1;
                wait_cycles(1);
                rx_ready = 1'b0;
            end
        join
        wait_cycles(4);
        watch_full = 1'b0;
        n_checks++;
        if (ov_cnt != ov0 || full_dropped !== 1'b0 || fifo_full !== 1'b1) begin
            n_fail++;
            $display("FAIL pop_push_full: ov=%0d dropped=%b full=%b expected 0/0/1",
                     ov_cnt - ov0, full_dropped, fifo_full);
        end
        n_checks++;
        if (rx_data !== 8'h61) begin
            n_fail++; $display("FAIL pop_push_head: rx_data=%h expected 61", rx_data);
        end
        rx_ready = 1'b1;
        wait_cycles(24);
        n_checks++;
        if (rxq.size() - q0 != 17 || rxq[q0] !== 8'h60 || rxq[q0 + 15] !== 8'h6F
            || rxq[q0 + 16] !== 8'h77) begin
            n_fail++;
            $display("FAIL pop_push_order: count=%0d expected 17 ending 6f,77", rxq.size() - q0);
        end
        n_checks++;
        if (rx_valid !== 1'b0 || fifo_full !== 1'b0) begin
            n_fail++; $display("FAIL pop_push_empty: valid=%b full=%b expected 0/0", rx_valid, fifo_full);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_single_frame();
        test_overrun();
        test_frame_error();
        test_glitch();
        test_reset_mid_frame();
        test_full_pop_push();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
